// File: rtl/servo_pwm_decoder_if.sv
// Signal bundle for the servo PWM decoder: enable and PWM line in, decoded position and status out.
interface servo_pwm_decoder_if;
    logic       ena;
    logic       pwm_in;
    logic [7:0] position;
    logic       valid;
    logic       sample_stb;
    logic       pulse_err;
    logic       timeout;

    modport master (
        output ena, pwm_in,
        input  position, valid, sample_stb, pulse_err, timeout
    );

    modport slave (
        input  ena, pwm_in,
        output position, valid, sample_stb, pulse_err, timeout
    );
endinterface

// File: rtl/servo_pwm_decoder.sv
// Measures the high time of a servo PWM pulse and maps it to an 8-bit position, with
// short/long pulse rejection and a frame-loss timeout.
module servo_pwm_decoder #(
    parameter int unsigned MIN_WIDTH     = 10000,
    parameter int unsigned STEP          = 40,
    parameter int unsigned SHORT_LIMIT   = 5000,
    parameter int unsigned LONG_LIMIT    = 25000,
    parameter int unsigned FRAME_TIMEOUT = 250000
) (
    input logic                clk,
    input logic                reset,
    servo_pwm_decoder_if.slave bus
);
    localparam logic [20:0] MIN_W     = 21'(MIN_WIDTH);
    localparam logic [20:0] STEP_W    = 21'(STEP);
    localparam logic [20:0] SHORT_W   = 21'(SHORT_LIMIT);
    localparam logic [20:0] LONG_W    = 21'(LONG_LIMIT);
    localparam logic [20:0] TIMEOUT_W = 21'(FRAME_TIMEOUT);
    localparam logic [20:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {SYNC, IDLE, HIGH, REJECT} state_t;

    state_t      state;
    logic        sync1, sync2, sync3;
    logic [1:0]  sync_fill;
    logic [20:0] width_cnt, step_cnt, frame_cnt;
    logic [7:0]  acc, pend_pos, position_q;
    logic        pend, valid_q, sample_stb_q, pulse_err_q, timeout_q;

    logic        rise, fall;
    logic [20:0] width_next, frame_next, step_inc, adv_cnt, adv_step;
    logic [7:0]  adv_acc;

    assign rise       = sync2 & ~sync3;
    assign fall       = ~sync2 & sync3;
    assign width_next = (width_cnt == CNT_MAX) ? width_cnt : width_cnt + 21'd1;
    assign frame_next = (frame_cnt == CNT_MAX) ? frame_cnt : frame_cnt + 21'd1;
    assign step_inc   = (step_cnt == CNT_MAX) ? step_cnt : step_cnt + 21'd1;
    assign adv_cnt    = (state == IDLE) ? 21'd1 : width_next;

    // Every STEP high cycles past MIN_WIDTH bump the saturating position accumulator.
    always_comb begin
        adv_step = step_cnt;
        adv_acc  = acc;
        if (adv_cnt > MIN_W) begin
            if (step_inc >= STEP_W) begin
                adv_step = '0;
                adv_acc  = (acc == 8'hFF) ? acc : acc + 8'd1;
            end else begin
                adv_step = step_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= SYNC;
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            sync3        <= 1'b0;
            sync_fill    <= 2'b00;
            width_cnt    <= '0;
            step_cnt     <= '0;
            frame_cnt    <= '0;
            acc          <= '0;
            pend_pos     <= '0;
            pend         <= 1'b0;
            position_q   <= '0;
            valid_q      <= 1'b0;
            sample_stb_q <= 1'b0;
            pulse_err_q  <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            sync1        <= bus.pwm_in;
            sync2        <= sync1;
            sync3        <= sync2;
            sync_fill    <= {sync_fill[0], 1'b1};
            sample_stb_q <= 1'b0;
            pulse_err_q  <= 1'b0;

            if (!bus.ena) begin
                state     <= SYNC;
                width_cnt <= '0;
                step_cnt  <= '0;
                frame_cnt <= '0;
                acc       <= '0;
                pend      <= 1'b0;
            end else begin
                // A rise in the same cycle as the timeout wins, so no timeout is raised.
                if (rise) begin
                    frame_cnt <= '0;
                end else begin
                    frame_cnt <= frame_next;
                    if (frame_next == TIMEOUT_W) begin
                        valid_q   <= 1'b0;
                        timeout_q <= 1'b1;
                    end
                end

                if (pend) begin
                    position_q   <= pend_pos;
                    valid_q      <= 1'b1;
                    timeout_q    <= 1'b0;
                    sample_stb_q <= 1'b1;
                    pend         <= 1'b0;
                end

                // sync_fill keeps the reset value of the synchronizer from passing as a real low.
                case (state)
                    SYNC: begin
                        if (sync_fill[1] && !sync2) state <= IDLE;
                    end
                    IDLE: begin
                        if (rise) begin
                            state     <= HIGH;
                            width_cnt <= 21'd1;
                            step_cnt  <= adv_step;
                            acc       <= adv_acc;
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            state <= IDLE;
                            if (width_cnt < SHORT_W) begin
                                pulse_err_q <= 1'b1;
                            end else begin
                                pend     <= 1'b1;
                                pend_pos <= acc;
                            end
                            width_cnt <= '0;
                            step_cnt  <= '0;
                            acc       <= '0;
                        end else if (width_next > LONG_W) begin
                            state       <= REJECT;
                            pulse_err_q <= 1'b1;
                            width_cnt   <= '0;
                            step_cnt    <= '0;
                            acc         <= '0;
                        end else begin
                            width_cnt <= width_next;
                            step_cnt  <= adv_step;
                            acc       <= adv_acc;
                        end
                    end
                    REJECT: begin
                        if (!sync2) state <= IDLE;
                    end
                    default: state <= SYNC;
                endcase
            end
        end
    end

    assign bus.position   = position_q;
    assign bus.valid      = valid_q;
    assign bus.sample_stb = sample_stb_q;
    assign bus.pulse_err  = pulse_err_q;
    assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Scoreboard bench for servo_pwm_decoder using scaled-down timing parameters.
module tb_servo_pwm_decoder;
    localparam int MIN_W     = 500;
    localparam int STEP_W    = 2;
    localparam int SHORT_W   = 250;
    localparam int LONG_W    = 1250;
    localparam int TIMEOUT_W = 12500;

    typedef struct {
        int pos;
        int cycle;
    } sample_t;

    logic clk = 1'b0;
    logic reset;

    sample_t sampleQ[$];
    int      errQ[$];
    int      vectorCount = 0;
    int      failCount   = 0;
    int      cycleCount  = 0;
    logic    timeoutSeen = 1'b0;
    sample_t monSample;
    int      monErr;

    servo_pwm_decoder_if bus();

    servo_pwm_decoder #(
        .MIN_WIDTH    (MIN_W),
        .STEP         (STEP_W),
        .SHORT_LIMIT  (SHORT_W),
        .LONG_LIMIT   (LONG_W),
        .FRAME_TIMEOUT(TIMEOUT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectorCount++;
        if (observed != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cycleCount);
        end
    endtask

    function automatic int modelPosition(input int width);
        int q;
        if (width <= MIN_W) return 0;
        q = (width - MIN_W) / STEP_W;
        return (q > 255) ? 255 : q;
    endfunction

    // Drives one pulse starting at the current negedge and records what the DUT must report.
    task automatic applyStimulus(input int width, input int lowCycles);
        int      riseCycle;
        sample_t expEntry;
        riseCycle  = cycleCount;
        bus.pwm_in = 1'b1;
        if (width > LONG_W) errQ.push_back(riseCycle + LONG_W + 3);
        repeat (width) @(negedge clk);
        bus.pwm_in = 1'b0;
        if (width < SHORT_W) begin
            errQ.push_back(cycleCount + 3);
        end else if (width <= LONG_W) begin
            expEntry.pos   = modelPosition(width);
            expEntry.cycle = cycleCount + 4;
            sampleQ.push_back(expEntry);
        end
        repeat (lowCycles) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (bus.timeout) timeoutSeen = 1'b1;
        if (bus.sample_stb) begin
            checkOutput("stb_expected", int'(sampleQ.size() > 0), 1);
            if (sampleQ.size() > 0) begin
                monSample = sampleQ.pop_front();
                checkOutput("position", int'(bus.position), monSample.pos);
                checkOutput("stb_latency", cycleCount, monSample.cycle);
                checkOutput("valid_on_stb", int'(bus.valid), 1);
                checkOutput("timeout_on_stb", int'(bus.timeout), 0);
            end
        end
        if (bus.pulse_err) begin
            checkOutput("err_expected", int'(errQ.size() > 0), 1);
            if (errQ.size() > 0) begin
                monErr = errQ.pop_front();
                checkOutput("err_cycle", cycleCount, monErr);
            end
        end
    end

    initial begin
        int basic[4];
        int edges[8];
        basic = '{500, 450, 1010, 1200};
        edges = '{SHORT_W, SHORT_W - 1, LONG_W, LONG_W + 1,
                  MIN_W + STEP_W - 1, MIN_W + STEP_W, 1008, 1009};

        bus.ena    = 1'b1;
        bus.pwm_in = 1'b0;
        reset      = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("rst_position", int'(bus.position), 0);
        checkOutput("rst_valid", int'(bus.valid), 0);
        checkOutput("rst_timeout", int'(bus.timeout), 0);
        checkOutput("rst_stb", int'(bus.sample_stb), 0);
        checkOutput("rst_err", int'(bus.pulse_err), 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        applyStimulus(750, 200);
        checkOutput("first_valid", int'(bus.valid), 1);
        checkOutput("first_position", int'(bus.position), 125);

        foreach (basic[i]) applyStimulus(basic[i], 200);

        applyStimulus(200, 200);
        checkOutput("short_pos_held", int'(bus.position), 255);
        checkOutput("short_valid_held", int'(bus.valid), 1);

        applyStimulus(1500, 200);
        checkOutput("long_pos_held", int'(bus.position), 255);
        checkOutput("long_valid_held", int'(bus.valid), 1);
        applyStimulus(750, 200);
        checkOutput("recover_position", int'(bus.position), 125);

        foreach (edges[i]) applyStimulus(edges[i], 200);

        repeat (5) applyStimulus(int'($urandom_range(LONG_W, SHORT_W)), 200);

        timeoutSeen = 1'b0;
        applyStimulus(750, TIMEOUT_W - 750);
        applyStimulus(750, 200);
        checkOutput("tie_no_timeout", int'(timeoutSeen), 0);

        timeoutSeen = 1'b0;
        applyStimulus(750, TIMEOUT_W - 749);
        applyStimulus(750, 200);
        checkOutput("late_timeout", int'(timeoutSeen), 1);

        applyStimulus(750, TIMEOUT_W + 50);
        checkOutput("to_valid", int'(bus.valid), 0);
        checkOutput("to_timeout", int'(bus.timeout), 1);
        checkOutput("to_position", int'(bus.position), 125);
        applyStimulus(600, 200);
        checkOutput("after_to_position", int'(bus.position), 50);
        checkOutput("after_to_valid", int'(bus.valid), 1);
        checkOutput("after_to_timeout", int'(bus.timeout), 0);

        bus.pwm_in = 1'b1;
        repeat (300) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("midrst_position", int'(bus.position), 0);
        checkOutput("midrst_valid", int'(bus.valid), 0);
        reset = 1'b0;
        repeat (400) @(negedge clk);
        bus.pwm_in = 1'b0;
        repeat (300) @(negedge clk);
        checkOutput("partial_ignored_valid", int'(bus.valid), 0);
        applyStimulus(750, 200);
        checkOutput("post_rst_position", int'(bus.position), 125);

        bus.pwm_in = 1'b1;
        repeat (300) @(negedge clk);
        bus.ena = 1'b0;
        repeat (100) @(negedge clk);
        checkOutput("ena_low_position", int'(bus.position), 125);
        checkOutput("ena_low_valid", int'(bus.valid), 1);
        bus.ena = 1'b1;
        repeat (300) @(negedge clk);
        bus.pwm_in = 1'b0;
        repeat (200) @(negedge clk);
        checkOutput("ena_pulse_dropped", int'(bus.position), 125);
        applyStimulus(1010, 200);
        checkOutput("post_ena_position", int'(bus.position), 255);

        repeat (20) @(negedge clk);
        checkOutput("sample_queue_empty", sampleQ.size(), 0);
        checkOutput("err_queue_empty", errQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
        $finish;
    end
endmodule

// File: doc/servo_pwm_decoder.md
SERVO_PWM_DECODER -- requirements
Module: servo_pwm_decoder

Interface
REQ-001 Parameter MIN_WIDTH, default 10000, meaning high-time in clk cycles that maps to position 0 (1.0 ms at 10 MHz).
REQ-002 Parameter STEP, default 40, meaning clk cycles of high-time per position LSB above MIN_WIDTH.
REQ-003 Parameter SHORT_LIMIT, default 5000, meaning pulses with high-time below this are errors.
REQ-004 Parameter LONG_LIMIT, default 25000, meaning pulses with high-time above this are errors.
REQ-005 Parameter FRAME_TIMEOUT, default 250000, meaning clk cycles without a rising edge before timeout (25 ms).
REQ-006 clk  input  1  clock; all logic on rising edge.
REQ-007 reset  input  1  reset, synchronous, active-high.
REQ-008 ena  input  1  block enable.
REQ-009 pwm_in  input  1  asynchronous servo PWM line, active-high pulse.
REQ-010 position  output  8  last decoded position, 0..255.
REQ-011 valid  output  1  position reflects a pulse received within FRAME_TIMEOUT.
REQ-012 sample_stb  output  1  one-cycle strobe when position is updated.
REQ-013 pulse_err  output  1  one-cycle strobe on a rejected pulse.
REQ-014 timeout  output  1  level, set on frame timeout, cleared by next accepted pulse.

Function
REQ-015 pwm_in SHALL pass through a 2-flop synchronizer; edges SHALL be detected by comparing synchronizer output with one further registered copy.
REQ-016 All internal counters SHALL be 21 bits, saturating at their maximum; all parameters SHALL be < 2^21.
REQ-017 FSM states SHALL be SYNC (wait for low), IDLE (low, wait for rise), HIGH (measuring), and REJECT (wait for low after an over-long pulse).
REQ-018 SYNC -> IDLE when synchronized input is low; IDLE -> HIGH on rising edge; HIGH -> IDLE on falling edge; HIGH -> REJECT when high-time exceeds LONG_LIMIT; REJECT -> IDLE when the input is low.
REQ-019 For a pulse of W clk cycles at pwm_in, decoded value SHALL be min(255, floor(max(0, W - MIN_WIDTH) / STEP)), exactly, without a divider (prescaled step counter plus 8-bit saturating accumulator).
REQ-020 On the falling edge with SHORT_LIMIT <= W <= LONG_LIMIT: position <= decoded value, valid <= 1, timeout <= 0, sample_stb pulses one cycle later than the detected edge.
REQ-021 On the falling edge with W < SHORT_LIMIT: position and valid unchanged, pulse_err pulses one cycle.
REQ-022 On entry to REJECT: pulse_err pulses one cycle; position and valid unchanged; no sample_stb for that pulse.
REQ-023 The frame counter SHALL clear on every rising edge and otherwise increment; on reaching FRAME_TIMEOUT, valid <= 0 and timeout <= 1; position holds its last value.
REQ-024 A rising edge in the same cycle the frame counter reaches FRAME_TIMEOUT SHALL take priority: no timeout asserted.
REQ-025 Latency from pwm_in falling edge to sample_stb SHALL be 4 clk cycles, constant.
REQ-026 With ena low: FSM SHALL be forced to SYNC, width/step/frame counters cleared, outputs held, strobes low; measuring resumes only after a full low-to-high transition following ena rising.

Reset
REQ-027 While reset is high on a clk edge: position=0, valid=0, sample_stb=0, pulse_err=0, timeout=0, FSM=SYNC, all counters and synchronizer flops 0.
REQ-028 A pulse already high when reset (or ena) deasserts SHALL be discarded; the first measured pulse is the next full one.
REQ-029 Reset SHALL override ena and all other inputs.

Verification
REQ-030 Pulse W=15000 after reset -> position=125, valid=1, one sample_stb 4 cycles after the falling edge.
REQ-031 Pulses W=10000, 9000, 20200, 24000 -> position 0, 0, 255, 255 respectively, each with sample_stb.
REQ-032 Pulse W=4000 -> pulse_err one cycle, position/valid unchanged; pulse W=30000 -> pulse_err at cycle 25001 of high time, no sample_stb, FSM recovers on the next good pulse.
REQ-033 Valid pulse, then line held low 250000 cycles -> valid=0, timeout=1, position held; next W=12000 pulse -> position=50, valid=1, timeout=0.
REQ-034 Reset asserted mid-pulse, released while pwm_in high -> that pulse ignored (no strobe); following W=15000 pulse -> position=125.
REQ-035 ena dropped for 100 cycles mid-pulse -> no strobe for that pulse, outputs held, next full pulse decoded correctly.
